// File: rtl/instruction_fetch_if.sv
// Host program-load channel: valid/ready beats carrying one instruction word each.
interface instruction_fetch_if #(
  parameter int INSTR_WIDTH = 32
);
  logic                   load_valid;
  logic                   load_ready;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/instruction_fetch.sv
// Program store and zero-bubble fetch stage: host loads the program, start releases the
// control unit, then mem[next_program_counter] is returned registered every cycle.
module instruction_fetch #(
  parameter int                     PC_WIDTH    = 10,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_fetch_if.slave     load,
  input  logic                   start,
  input  logic                   reload,
  input  logic [PC_WIDTH-1:0]    next_program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   core_rst,
  output logic                   running,
  output logic [PC_WIDTH:0]      load_count,
  output logic                   load_overflow
);
  localparam int DEPTH = 2 ** PC_WIDTH;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    wptr;
  logic [PC_WIDTH-1:0]    rd_addr;
  logic                   accept;
  logic                   force_nop;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  assign load.load_ready = (state == ST_LOAD);
  assign core_rst        = (state != ST_RUN);
  assign running         = (state == ST_RUN);
  assign accept          = load.load_valid && (state == ST_LOAD);

  always_comb begin
    rd_addr = '0;
    if (state == ST_RUN) rd_addr = next_program_counter;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD;
      wptr          <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wptr       <= wptr + PC_WIDTH'(1);
            load_count <= load_count + (PC_WIDTH + 1)'(1);
            if (load.load_last) begin
              state <= ST_READY;
            end else if (wptr == '1) begin
              state         <= ST_READY;
              load_overflow <= 1'b1;
            end
          end
        end
        ST_READY, ST_RUN: begin
          if (reload) begin
            state         <= ST_LOAD;
            wptr          <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
          end else if (state == ST_READY && start) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Write port: only ever active in LOAD, so it never collides with the read port.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= load.load_data;
  end

  // NOP is also forced on the reload edge so the core sees NOP as soon as it is re-held.
  assign force_nop = rst || (state == ST_LOAD) || reload;

  always_ff @(posedge clk) begin
    if (force_nop) instruction <= NOP_WORD;
    else           instruction <= mem[rd_addr];
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch against a behavioural program-store model.
module tb_instruction_fetch;
  localparam int PCW   = 3;
  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           reload = 1'b0;
  logic [PCW-1:0] next_pc = '0;
  logic [IW-1:0]  instruction;
  logic           core_rst, running, load_overflow;
  logic [PCW:0]   load_count;

  instruction_fetch_if #(.INSTR_WIDTH(IW)) lif ();

  instruction_fetch #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .NOP_WORD(NOP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .load                 (lif),
    .start                (start),
    .reload               (reload),
    .next_program_counter (next_pc),
    .instruction          (instruction),
    .core_rst             (core_rst),
    .running              (running),
    .load_count           (load_count),
    .load_overflow        (load_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: what the program store should hold and which phase the host is in.
  logic [IW-1:0] model_mem [DEPTH];
  int  m_wptr, m_count;
  bit  m_loading, m_running, m_ovf;
  logic [IW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".load_ready"}, 64'(lif.load_ready), 64'(m_loading));
    check({tag, ".core_rst"}, 64'(core_rst), 64'(!m_running));
    check({tag, ".running"}, 64'(running), 64'(m_running));
    check({tag, ".load_count"}, 64'(load_count), 64'(m_count));
    check({tag, ".load_overflow"}, 64'(load_overflow), 64'(m_ovf));
  endtask

  task automatic model_begin_load();
    m_wptr = 0; m_count = 0; m_ovf = 0; m_loading = 1; m_running = 0;
  endtask

  task automatic load_beat(input logic [IW-1:0] d, input bit last, input int gap);
    bit acc;
    repeat (gap) @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_last  = last;
    check("beat_ready", 64'(lif.load_ready), 64'(m_loading));
    acc = m_loading;
    @(negedge clk);
    lif.load_valid = 1'b0;
    if (acc) begin
      model_mem[m_wptr] = d;
      m_count++;
      if (last) m_loading = 0;
      else if (m_wptr == DEPTH - 1) begin
        m_loading = 0;
        m_ovf = 1;
      end
      m_wptr = (m_wptr + 1) % DEPTH;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!m_loading) m_running = 1;
  endtask

  task automatic do_reload(input bit with_start);
    reload = 1'b1;
    start  = with_start;
    @(negedge clk);
    reload = 1'b0;
    start  = 1'b0;
    if (!m_loading) model_begin_load();
  endtask

  task automatic issue_pc(input int pc);
    next_pc = PCW'(pc);
    exp_q.push_back(model_mem[pc % DEPTH]);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one fetch result per issued PC, visible just after the following edge.
  initial begin
    logic [IW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fetch", 64'(instruction), 64'(e));
      end
    end
  end

  initial begin
    logic [IW-1:0] w [4];
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_last  = 1'b0;
    model_begin_load();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_status("reset");
    check("reset.instruction", 64'(instruction), 64'(NOP));

    // Fill memory without load_last: overflow, then a refused 9th beat.
    for (int i = 0; i < DEPTH; i++) load_beat($urandom, 1'b0, int'($urandom_range(0, 2)));
    check_status("overflow");
    load_beat(32'hBAD0_BAD0, 1'b0, 0);
    check_status("beat9");
    check("ready.instruction", 64'(instruction), 64'(model_mem[0]));

    do_start();
    check_status("run1");
    check("start1.instruction", 64'(instruction), 64'(model_mem[0]));
    for (int i = 0; i < 20; i++) issue_pc(int'($urandom_range(0, DEPTH - 1)));
    drain();

    // start and reload together: reload wins.
    do_reload(1'b1);
    check_status("reload_start");
    check("reload.instruction", 64'(instruction), 64'(NOP));

    load_beat(32'h11, 1'b0, int'($urandom_range(0, 2)));
    load_beat(32'h22, 1'b0, int'($urandom_range(0, 2)));
    load_beat(32'h33, 1'b0, int'($urandom_range(0, 2)));
    load_beat(32'h44, 1'b1, int'($urandom_range(0, 2)));
    check_status("load4");
    lif.load_valid = 1'b1;
    lif.load_data  = 32'hDEAD_DEAD;
    lif.load_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", 64'(lif.load_ready), 64'(0));
      @(negedge clk);
    end
    lif.load_valid = 1'b0;
    check_status("stalled");
    check("ready4.instruction", 64'(instruction), 64'(32'h11));

    do_start();
    check_status("run2");
    check("start2.instruction", 64'(instruction), 64'(32'h11));
    issue_pc(1); issue_pc(2); issue_pc(0);
    for (int p = 4; p < DEPTH; p++) issue_pc(p);
    for (int i = 0; i < 10; i++) issue_pc(int'($urandom_range(0, DEPTH - 1)));
    drain();

    // Reload alone in RUN, then ignored start/reload during LOAD, then rst mid-load.
    do_reload(1'b0);
    check_status("reload");
    check("reload2.instruction", 64'(instruction), 64'(NOP));
    load_beat($urandom, 1'b0, 0);
    load_beat($urandom, 1'b0, 1);
    do_start();
    check_status("start_in_load");
    do_reload(1'b0);
    check_status("reload_in_load");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_begin_load();
    check_status("rst_midload");
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    load_beat(w[0], 1'b0, 0);
    load_beat(w[1], 1'b0, 1);
    load_beat(w[2], 1'b1, 0);
    check_status("load3");
    @(negedge clk);
    do_start();
    check("start3.instruction", 64'(instruction), 64'(w[0]));
    for (int p = 0; p < 4; p++) issue_pc(p);
    drain();
    check("keep_mem3", 64'(model_mem[3]), 64'(32'h44) | 64'(instruction & 32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
